// File: rtl/mux_scan_nto1.sv
// N-channel, W-bit registered multiplexer with a manual-select mode and an
// auto-scan mode that holds each channel for DWELL enabled clocks.
module mux_scan_nto1 #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    out,
  output logic [SW-1:0]   out_ch,
  output logic            out_vld,
  output logic            wrap,
  output logic            sel_err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] LAST_CH  = SW'(N - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  // Handshake: out/out_ch are meaningful only in a cycle where out_vld is 1;
  // there is no back-pressure, the consumer must take every valid sample.
  typedef enum logic {MAN, SCAN} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_q, out_d;
  logic [SW-1:0]   out_ch_q, out_ch_d;
  logic            out_vld_q, out_vld_d;
  logic            wrap_q, wrap_d;
  logic            sel_err_q, sel_err_d;

  logic            sel_ok;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    ch_data;

  // With a power-of-two channel count every select code is a real channel.
  generate
    if ((1 << SW) == N) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = (sel < SW'(N));
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    ch_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) sel_data = in[k*W +: W];
      if (ch_q == SW'(k)) ch_data = in[k*W +: W];
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_ch_d  = out_ch_q;
    out_vld_d = 1'b0;
    wrap_d    = 1'b0;
    sel_err_d = sel_err_q;
    if (en) begin
      if (state_q == SCAN && mode) begin
        out_d     = ch_data;
        out_ch_d  = ch_q;
        out_vld_d = 1'b1;
        sel_err_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          cnt_d  = '0;
          ch_d   = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          wrap_d = (ch_q == LAST_CH);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // Manual output also on the entry edge and on the edge leaving scan.
        if (sel_ok) begin
          out_d     = sel_data;
          out_ch_d  = sel;
          out_vld_d = 1'b1;
          sel_err_d = 1'b0;
        end else begin
          out_d     = '0;
          out_ch_d  = '0;
          out_vld_d = 1'b0;
          sel_err_d = 1'b1;
        end
        if (mode) begin
          state_d = SCAN;
          ch_d    = sel_ok ? sel : '0;
          cnt_d   = '0;
        end else begin
          state_d = MAN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MAN;
      ch_q      <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_ch_q  <= '0;
      out_vld_q <= 1'b0;
      wrap_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_ch_q  <= out_ch_d;
      out_vld_q <= out_vld_d;
      wrap_q    <= wrap_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out     = out_q;
  assign out_ch  = out_ch_q;
  assign out_vld = out_vld_q;
  assign wrap    = wrap_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1: three configurations (N4/W8/DWELL4, N3/W4/DWELL4,
// N4/W8/DWELL1) driven by directed steps, checked through per-instance queues.
module tb_mux_scan_nto1;

  localparam int EW = 13;  // {vld, err, wrap, ch[1:0], data[7:0]}

  logic clk;
  logic rst_n;

  logic [31:0] in_a;  logic [1:0] sel_a;  logic mode_a, en_a;
  logic [7:0]  out_a; logic [1:0] ch_a;   logic vld_a, wrap_a, err_a;
  logic [11:0] in_b;  logic [1:0] sel_b;  logic mode_b, en_b;
  logic [3:0]  out_b; logic [1:0] ch_b;   logic vld_b, wrap_b, err_b;
  logic [31:0] in_c;  logic [1:0] sel_c;  logic mode_c, en_c;
  logic [7:0]  out_c; logic [1:0] ch_c;   logic vld_c, wrap_c, err_c;

  logic [EW-1:0] qa[$];
  logic [EW-1:0] qb[$];
  logic [EW-1:0] qc[$];

  int n_cmp;
  int n_bad;

  mux_scan_nto1 #(.N(4), .W(8), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .sel(sel_a), .mode(mode_a), .en(en_a),
    .out(out_a), .out_ch(ch_a), .out_vld(vld_a), .wrap(wrap_a), .sel_err(err_a));

  mux_scan_nto1 #(.N(3), .W(4), .DWELL(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .sel(sel_b), .mode(mode_b), .en(en_b),
    .out(out_b), .out_ch(ch_b), .out_vld(vld_b), .wrap(wrap_b), .sel_err(err_b));

  mux_scan_nto1 #(.N(4), .W(8), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .sel(sel_c), .mode(mode_c), .en(en_c),
    .out(out_c), .out_ch(ch_c), .out_vld(vld_c), .wrap(wrap_c), .sel_err(err_c));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pk(input logic v, input logic e, input logic w,
                                       input logic [1:0] c, input logic [7:0] d);
    return {v, e, w, c, d};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got vld=%0b err=%0b wrap=%0b ch=%0d data=%h, expected vld=%0b err=%0b wrap=%0b ch=%0d data=%h",
               name, act[12], act[11], act[10], act[9:8], act[7:0],
               exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic chk_empty(input string name, input int depth);
    n_cmp++;
    if (depth != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected samples never presented, required 0", name, depth);
    end
  endtask

  // Monitor: pops one expected sample per clock for each instance.
  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("mon_a", pk(vld_a, err_a, wrap_a, ch_a, out_a), e);
      end else if (vld_a) begin
        chk("mon_a_unexpected", pk(vld_a, err_a, wrap_a, ch_a, out_a), '0);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("mon_b", pk(vld_b, err_b, wrap_b, ch_b, {4'b0, out_b}), e);
      end else if (vld_b) begin
        chk("mon_b_unexpected", pk(vld_b, err_b, wrap_b, ch_b, {4'b0, out_b}), '0);
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        chk("mon_c", pk(vld_c, err_c, wrap_c, ch_c, out_c), e);
      end else if (vld_c) begin
        chk("mon_c_unexpected", pk(vld_c, err_c, wrap_c, ch_c, out_c), '0);
      end
    end
  endtask

  // Driver: apply inputs, clock once, queue the sample expected after that edge.
  task automatic step(input int id, input logic [1:0] s, input logic m, input logic e,
                      input logic [31:0] din, input logic [EW-1:0] exp);
    case (id)
      0: begin in_a = din;        sel_a = s; mode_a = m; en_a = e; end
      1: begin in_b = din[11:0];  sel_b = s; mode_b = m; en_b = e; end
      default: begin in_c = din;  sel_c = s; mode_c = m; en_c = e; end
    endcase
    @(posedge clk);
    case (id)
      0: qa.push_back(exp);
      1: qb.push_back(exp);
      default: qc.push_back(exp);
    endcase
    #1;
  endtask

  initial begin
    logic [31:0] a0;
    logic [31:0] din;
    logic [1:0]  c;
    logic [7:0]  d;
    logic [7:0]  b_tab [3];

    n_cmp = 0;
    n_bad = 0;
    a0 = 32'h4433_2211;
    in_a = '0; sel_a = '0; mode_a = 1'b0; en_a = 1'b0;
    in_b = '0; sel_b = '0; mode_b = 1'b0; en_b = 1'b0;
    in_c = '0; sel_c = '0; mode_c = 1'b0; en_c = 1'b0;
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", pk(vld_a, err_a, wrap_a, ch_a, out_a), '0);
    chk("reset_b", pk(vld_b, err_b, wrap_b, ch_b, {4'b0, out_b}), '0);
    chk("reset_c", pk(vld_c, err_c, wrap_c, ch_c, out_c), '0);
    rst_n = 1'b1;

    // Manual sweep, then asynchronous reset between clock edges
    for (int s = 0; s < 4; s++)
      step(0, 2'(s), 1'b0, 1'b1, a0, pk(1'b1, 1'b0, 1'b0, 2'(s), 8'(8'h11 * (s + 1))));
    step(0, 2'd2, 1'b0, 1'b1, a0, pk(1'b1, 1'b0, 1'b0, 2'd2, 8'h33));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_a", pk(vld_a, err_a, wrap_a, ch_a, out_a), '0);
    qa.delete();
    en_a = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Auto-scan from channel 2; the entry edge still shows the manual pick
    step(0, 2'd2, 1'b1, 1'b1, a0, pk(1'b1, 1'b0, 1'b0, 2'd2, 8'h33));
    din = a0;
    for (int i = 0; i < 10; i++) begin
      c   = 2'((2 + i / 4) % 4);
      din = 32'(a0 + i * 32'h0101_0101);
      d   = 8'(8'h11 * (c + 1) + i);
      step(0, 2'd0, 1'b1, 1'b1, din, pk(1'b1, 1'b0, (i == 7), c, d));
    end
    // Channel 0 has used two of its four dwell clocks; freeze for three
    for (int i = 0; i < 3; i++)
      step(0, 2'd0, 1'b1, 1'b0, din, pk(1'b0, 1'b0, 1'b0, 2'd0, 8'h1A));
    step(0, 2'd0, 1'b1, 1'b1, din, pk(1'b1, 1'b0, 1'b0, 2'd0, 8'h1A));
    step(0, 2'd0, 1'b1, 1'b1, din, pk(1'b1, 1'b0, 1'b0, 2'd0, 8'h1A));
    step(0, 2'd0, 1'b1, 1'b1, din, pk(1'b1, 1'b0, 1'b0, 2'd1, 8'h2B));
    step(0, 2'd0, 1'b1, 1'b1, din, pk(1'b1, 1'b0, 1'b0, 2'd1, 8'h2B));
    // Leave scan at channel 1 straight to sel=3, then re-enter at channel 0
    step(0, 2'd3, 1'b0, 1'b1, din, pk(1'b1, 1'b0, 1'b0, 2'd3, 8'h4D));
    step(0, 2'd0, 1'b1, 1'b1, a0, pk(1'b1, 1'b0, 1'b0, 2'd0, 8'h11));
    for (int i = 0; i < 4; i++)
      step(0, 2'd3, 1'b1, 1'b1, a0, pk(1'b1, 1'b0, 1'b0, 2'd0, 8'h11));
    step(0, 2'd3, 1'b1, 1'b1, a0, pk(1'b1, 1'b0, 1'b0, 2'd1, 8'h22));
    step(0, 2'd3, 1'b0, 1'b0, a0, pk(1'b0, 1'b0, 1'b0, 2'd1, 8'h22));

    // Three channels: select code 3 is out of range
    b_tab[0] = 8'h05; b_tab[1] = 8'h0A; b_tab[2] = 8'h0C;
    step(1, 2'd3, 1'b0, 1'b1, 32'hCA5, pk(1'b0, 1'b1, 1'b0, 2'd0, 8'h00));
    step(1, 2'd3, 1'b0, 1'b0, 32'hCA5, pk(1'b0, 1'b1, 1'b0, 2'd0, 8'h00));
    step(1, 2'd1, 1'b0, 1'b1, 32'hCA5, pk(1'b1, 1'b0, 1'b0, 2'd1, 8'h0A));
    step(1, 2'd2, 1'b0, 1'b1, 32'hCA5, pk(1'b1, 1'b0, 1'b0, 2'd2, 8'h0C));
    step(1, 2'd3, 1'b0, 1'b1, 32'hCA5, pk(1'b0, 1'b1, 1'b0, 2'd0, 8'h00));
    step(1, 2'd3, 1'b1, 1'b1, 32'hCA5, pk(1'b0, 1'b1, 1'b0, 2'd0, 8'h00));
    for (int i = 0; i < 13; i++) begin
      c = 2'((i / 4) % 3);
      step(1, 2'd1, 1'b1, 1'b1, 32'hCA5, pk(1'b1, 1'b0, (i == 11), c, b_tab[c]));
    end
    step(1, 2'd1, 1'b1, 1'b0, 32'hCA5, pk(1'b0, 1'b0, 1'b0, 2'd0, 8'h05));

    // One clock per channel: wrap every fourth scan sample
    step(2, 2'd0, 1'b1, 1'b1, 32'hDDCC_BBAA, pk(1'b1, 1'b0, 1'b0, 2'd0, 8'hAA));
    for (int i = 0; i < 12; i++) begin
      c = 2'(i % 4);
      d = 8'(8'hAA + 8'h11 * c);
      step(2, 2'd0, 1'b1, 1'b1, 32'hDDCC_BBAA, pk(1'b1, 1'b0, (c == 2'd3), c, d));
    end
    step(2, 2'd0, 1'b1, 1'b0, 32'hDDCC_BBAA, pk(1'b0, 1'b0, 1'b0, 2'd3, 8'hDD));

    repeat (2) @(negedge clk);
    #1;
    chk_empty("drain_a", qa.size());
    chk_empty("drain_b", qb.size());
    chk_empty("drain_c", qc.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
